// File: rtl/cook_timer_pkg.sv
// Shared definitions for the cook timer controller.
//   state_t      : controller FSM states
//   BCD_MAX_*    : largest legal BCD digit for units / seconds-tens positions
//   DONE_CNT_W   : width of the done-phase tick counter (DONE_TICKS up to 15)
package cook_timer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX_UNIT = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

    localparam int unsigned DONE_CNT_W = 4;

endpackage

// File: rtl/cook_timer_ctrl_bcd_mmss_dec.sv
// Combinational M:SS BCD decrementer.
//   i_min_ones/i_sec_tens/i_sec_ones : current time digits
//   o_min_ones/o_sec_tens/o_sec_ones : time minus one second (0:00 saturates)
//   o_is_zero                        : decremented result is 0:00
module bcd_mmss_dec
    import cook_timer_pkg::*;
(
    input  logic [3:0] i_min_ones,
    input  logic [3:0] i_sec_tens,
    input  logic [3:0] i_sec_ones,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_sec_ones,
    output logic       o_is_zero
);

    always_comb begin
        o_min_ones = i_min_ones;
        o_sec_tens = i_sec_tens;
        o_sec_ones = i_sec_ones;
        if (i_sec_ones != 4'd0) begin
            o_sec_ones = i_sec_ones - 4'd1;
        end else if (i_sec_tens != 4'd0) begin
            o_sec_ones = BCD_MAX_UNIT;
            o_sec_tens = i_sec_tens - 4'd1;
        end else if (i_min_ones != 4'd0) begin
            o_sec_ones = BCD_MAX_UNIT;
            o_sec_tens = BCD_MAX_TENS;
            o_min_ones = i_min_ones - 4'd1;
        end
        o_is_zero = (o_min_ones == 4'd0) && (o_sec_tens == 4'd0) && (o_sec_ones == 4'd0);
    end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer sequencer: keypad digit entry, countdown, magnetron gating.
//   clk, clearn           : clock, async active-low reset
//   D, loadn              : BCD digit and active-low data-valid from the keypad encoder
//   tick_1hz              : one-clk pulse per second
//   startn, stopn         : debounced active-low buttons
//   door_closed           : 1 = door closed
//   enbn                  : 1 = keypad locked
//   min_ones/sec_tens/sec_ones : displayed M:SS time
//   mag_on                : magnetron enable (combinational)
//   done                  : cook complete indicator
module cook_timer_ctrl
    import cook_timer_pkg::*;
#(
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       tick_1hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       enbn,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       done
);

    localparam logic [DONE_CNT_W-1:0] LP_DONE_LAST = DONE_CNT_W'(DONE_TICKS - 1);

    state_t                r_state, w_state_nx;
    logic [3:0]            r_min, r_tens, r_ones;
    logic [3:0]            w_min_nx, w_tens_nx, w_ones_nx;
    logic [DONE_CNT_W-1:0] r_done_cnt, w_done_cnt_nx;
    logic                  r_loadn_prev, r_startn_prev, r_stopn_prev;
    logic                  r_enbn, r_done;

    logic       w_digit_ev, w_start_ev, w_stop_ev, w_time_zero;
    logic [3:0] w_dec_min, w_dec_tens, w_dec_ones;
    logic       w_dec_zero;

    // Digits above 9 never count as an event.
    assign w_digit_ev  = ~loadn & r_loadn_prev & (D <= BCD_MAX_UNIT);
    assign w_start_ev  = ~startn & r_startn_prev;
    assign w_stop_ev   = ~stopn & r_stopn_prev;
    assign w_time_zero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);

    bcd_mmss_dec u_dec (
        .i_min_ones (r_min),
        .i_sec_tens (r_tens),
        .i_sec_ones (r_ones),
        .o_min_ones (w_dec_min),
        .o_sec_tens (w_dec_tens),
        .o_sec_ones (w_dec_ones),
        .o_is_zero  (w_dec_zero)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_min_nx      = r_min;
        w_tens_nx     = r_tens;
        w_ones_nx     = r_ones;
        w_done_cnt_nx = r_done_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_digit_ev) begin
                    w_min_nx   = r_tens;
                    w_tens_nx  = r_ones;
                    w_ones_nx  = D;
                    w_state_nx = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (w_stop_ev) begin
                    w_min_nx   = 4'd0;
                    w_tens_nx  = 4'd0;
                    w_ones_nx  = 4'd0;
                    w_state_nx = S_IDLE;
                end else if (w_start_ev && door_closed && !w_time_zero) begin
                    // Entry like 1:75 means 2:15; anything past 9:59 clamps.
                    if (r_tens > BCD_MAX_TENS) begin
                        if (r_min == BCD_MAX_UNIT) begin
                            w_tens_nx = BCD_MAX_TENS;
                            w_ones_nx = BCD_MAX_UNIT;
                        end else begin
                            w_tens_nx = r_tens - 4'd6;
                            w_min_nx  = r_min + 4'd1;
                        end
                    end
                    w_state_nx = S_COOK;
                end else if (w_digit_ev) begin
                    w_min_nx  = r_tens;
                    w_tens_nx = r_ones;
                    w_ones_nx = D;
                end
            end
            S_COOK: begin
                if (w_stop_ev || !door_closed) begin
                    w_state_nx = S_PAUSE;
                end else if (tick_1hz) begin
                    w_min_nx  = w_dec_min;
                    w_tens_nx = w_dec_tens;
                    w_ones_nx = w_dec_ones;
                    if (w_dec_zero) begin
                        w_state_nx    = S_DONE;
                        w_done_cnt_nx = '0;
                    end
                end
            end
            S_PAUSE: begin
                if (w_stop_ev) begin
                    w_min_nx   = 4'd0;
                    w_tens_nx  = 4'd0;
                    w_ones_nx  = 4'd0;
                    w_state_nx = S_IDLE;
                end else if (w_start_ev && door_closed) begin
                    w_state_nx = S_COOK;
                end
            end
            S_DONE: begin
                if (w_stop_ev) begin
                    w_state_nx = S_IDLE;
                end else if (tick_1hz) begin
                    if (r_done_cnt == LP_DONE_LAST) begin
                        w_state_nx    = S_IDLE;
                        w_done_cnt_nx = '0;
                    end else begin
                        w_done_cnt_nx = r_done_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_state       <= S_IDLE;
            r_min         <= 4'd0;
            r_tens        <= 4'd0;
            r_ones        <= 4'd0;
            r_done_cnt    <= '0;
            r_loadn_prev  <= 1'b1;
            r_startn_prev <= 1'b1;
            r_stopn_prev  <= 1'b1;
            r_enbn        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_min         <= w_min_nx;
            r_tens        <= w_tens_nx;
            r_ones        <= w_ones_nx;
            r_done_cnt    <= w_done_cnt_nx;
            r_loadn_prev  <= loadn;
            r_startn_prev <= startn;
            r_stopn_prev  <= stopn;
            r_enbn        <= (w_state_nx == S_COOK) || (w_state_nx == S_PAUSE) ||
                             (w_state_nx == S_DONE);
            r_done        <= (w_state_nx == S_DONE);
        end
    end

    assign enbn     = r_enbn;
    assign done     = r_done;
    assign min_ones = r_min;
    assign sec_tens = r_tens;
    assign sec_ones = r_ones;
    // Combinational so an opening door kills power without waiting a clock.
    assign mag_on   = (r_state == S_COOK) & door_closed;

endmodule
